mult_div_iter: RTL

//  Parametrised iterative multiply/divide unit for the multicycle datapath: signed/unsigned

---
 rtl/mult_div_iter_if.sv | 29 ++
 rtl/mult_div_iter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mult_div_iter_if: start/busy/done handshake and Hi/Lo results  |
// | Revision 1.0                                                   |
// +----------------------------------------------------------------+
interface mult_div_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_iter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mult_div_iter: iterative signed/unsigned MULT/DIV into Hi/Lo   |
// | Revision 1.0                                                   |
// +----------------------------------------------------------------+
module mult_div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire logic      clk,
  input  wire logic      reset,
  mult_div_iter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    ADJUST = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CNT_W-1:0]   count;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               div_zero;

  logic               busy;
  logic               done;
  logic               accept;
  logic               divide_by_zero;
  logic               is_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    is_signed      = ~bus.op[0];
    mag_a          = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b          = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    divide_by_zero = bus.op[1] && (bus.b == '0);
    accept         = bus.start && ((state == IDLE) || (state == DONE));
    mul_sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    // Partial remainder is below the divisor, so the W+1-bit difference never overflows.
    div_diff       = div_shift - {1'b0, opnd};
    div_ge         = ~div_diff[WIDTH];
    prod_fix       = neg_q ? -acc : acc;
    quo_fix        = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix        = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = divide_by_zero ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == '0) begin
          state_next = ADJUST;
        end
      end
      ADJUST: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) begin
          state_next = divide_by_zero ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc      <= '0;
      opnd     <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            is_div   <= bus.op[1];
            neg_q    <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r    <= is_signed && bus.op[1] && bus.a[WIDTH-1];
            count    <= LAST_CNT;
            div_zero <= divide_by_zero;
            // Multiplier sits in the low half and is consumed LSB first;
            // for divide the dividend sits there and is consumed MSB first.
            if (bus.op[1]) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end
        end
        CALC: begin
          count <= count - 1'b1;
          if (is_div) begin
            acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                    acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        ADJUST: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.hi       = hi;
  assign bus.lo       = lo;
  assign bus.div_zero = div_zero;

endmodule
`default_nettype wire
